seq_mult_wb: RTL and testbench
==============================

Name: seq_mult_wb

Overview:
Sequential unsigned shift-add multiplier that sits directly downstream of the 8x16 register file.
- Drives the register file's read addresses and consumes its d_out_a / d_out_b operands.
- Computes the 2W-bit product over W cycles.
- Writes the product back into the register file through the write port (wr, wr_addr, d_in) as two W-bit halves.
- Acts as the multiply execution unit of the datapath.

Parameters:
W, 16, operand width; equals register file data width.
AW, 3, register address width (8 registers).

Ports:
clk  input  1  system clock, all state changes on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  request a multiply; sampled only in IDLE.
rs_a  input  AW  source register address for operand A.
rs_b  input  AW  source register address for operand B.
rd_lo  input  AW  destination register for product[W-1:0].
rd_hi  input  AW  destination register for product[2W-1:W].
rd_addr_a  output  AW  register file read address A.
rd_addr_b  output  AW  register file read address B.
d_out_a  input  W  register file read data A (combinational read).
d_out_b  input  W  register file read data B (combinational read).
wr  output  1  register file write enable.
wr_addr  output  AW  register file write address.
d_in  output  W  register file write data.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the high-half write completes.
product  output  2W  last completed product; held until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; address capture regs, multiplicand, multiplier, accumulator, bit counter, product = 0; wr=0, done=0, busy=0. An operation in flight is abandoned with no partial write; wr drops immediately.
- Register file read ports are combinational. The block drives rd_addr_a/rd_addr_b from captured registers and the register file returns data in the same cycle.
- States are IDLE, LOAD, MUL, WB_LO, WB_HI. Cycle numbering below counts from the clock edge that samples start=1 in IDLE (edge 0).
- IDLE: start=1 captures rs_a, rs_b, rd_lo, rd_hi and moves to LOAD.
  - start is ignored in all other states.
  - No queueing; a start pulse during busy is lost.
- LOAD (cycle 1): sample d_out_a into the multiplicand and d_out_b into the multiplier. Clear the 2W-bit accumulator, set counter=W, go to MUL.
- MUL (cycles 2..W+1): each cycle, if multiplier[0]=1, accumulator += multiplicand shifted left by (W - counter).
  - Equivalent right-shift formulation is allowed provided results are identical.
  - Shift the multiplier right by 1 and decrement the counter.
  - Exit to WB_LO when the counter reaches 0 (exactly W MUL cycles regardless of operand values; no early termination).
- WB_LO (cycle W+2): wr=1, wr_addr=rd_lo, d_in=acc[W-1:0].
- WB_HI (cycle W+3): wr=1, wr_addr=rd_hi, d_in=acc[2W-1:W]. At the exit edge, product<=acc and done<=1. Go to IDLE.
- done is high only during cycle W+4 (first IDLE cycle). start may be accepted in that same cycle.
- wr, wr_addr, d_in are decoded from state. wr=0 in IDLE, LOAD, MUL; wr_addr and d_in are 0 when wr=0.
- Arithmetic is unsigned and never overflows 2W bits. Examples: 0xFFFF*0xFFFF=0xFFFE0001; 0*x=0.
- rd_lo==rd_hi: both writes occur and the high half remains (last write wins).
- Destination equal to a source register is legal. Operands are latched in LOAD, so the writeback does not corrupt the computation.
- rs_a==rs_b is legal (squaring).
- Throughput is one multiply per W+4 cycles.

Test Plan:
- Reset then preload r3=0xcdef, r7=0x3210. Pulse start with rs_a=3, rs_b=7, rd_lo=5, rd_hi=0 → busy rises in cycle 1. wr=1 for exactly cycles 18-19 with (5,0x8CF0) then (0,0x2845); done pulse in cycle 20; product=0x28458CF0.
- r1=0xFFFF, rs_a=rs_b=1, rd_lo=2, rd_hi=3 → r2=0x0001, r3=0xFFFE, product=0xFFFE0001.
- Operand A=0 and B=0xBA98 → both writes occur with d_in=0x0000. Latency still 20 cycles (no early exit).
- rd_lo=rd_hi=4, r3=0x0003, r5=0x0005 → two writes to r4. Final r4=0x0000 (high half); product=0x0000000F.
- Second start pulsed in cycle 10 of an operation → ignored, no extra writes. A start held in the done cycle is accepted and busy reasserts the next cycle.
- Assert reset in cycle 12 of a multiply → busy, wr, done go 0 immediately. No register file write occurs and product stays 0.

Source files
------------

// File: rtl/seq_mult_wb.sv
// Sequential unsigned shift-add multiplier for the 8x16 register file.
// Reads two operands, multiplies over W cycles, writes the product back as two halves.
module seq_mult_wb #(
   parameter int W  = 16,
   parameter int AW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [AW-1:0]   rs_a,
   input  logic [AW-1:0]   rs_b,
   input  logic [AW-1:0]   rd_lo,
   input  logic [AW-1:0]   rd_hi,
   output logic [AW-1:0]   rd_addr_a,
   output logic [AW-1:0]   rd_addr_b,
   input  logic [W-1:0]    d_out_a,
   input  logic [W-1:0]    d_out_b,
   output logic            wr,
   output logic [AW-1:0]   wr_addr,
   output logic [W-1:0]    d_in,
   output logic            busy,
   output logic            done,
   output logic [2*W-1:0]  product
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {IDLE, LOAD, MUL, WB_LO, WB_HI} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   cap_a, cap_b, cap_lo, cap_hi;
   logic [2*W-1:0]  mcand;
   logic [2*W-1:0]  acc;
   logic [W-1:0]    mplier;
   logic [CW-1:0]   cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = MUL;
         MUL:     if (cnt == CW'(1)) state_nxt = WB_LO;
         WB_LO:   state_nxt = WB_HI;
         WB_HI:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiplicand is kept pre-shifted so each MUL cycle is a plain add.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_a   <= '0;
         cap_b   <= '0;
         cap_lo  <= '0;
         cap_hi  <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == WB_HI);
         unique case (state)
            IDLE: if (start) begin
               cap_a  <= rs_a;
               cap_b  <= rs_b;
               cap_lo <= rd_lo;
               cap_hi <= rd_hi;
            end
            LOAD: begin
               mcand  <= {{W{1'b0}}, d_out_a};
               mplier <= d_out_b;
               acc    <= '0;
               cnt    <= CW'(W);
            end
            MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
            end
            WB_HI:   product <= acc;
            default: ;
         endcase
      end
   end

   assign rd_addr_a = cap_a;
   assign rd_addr_b = cap_b;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      wr      = 1'b0;
      wr_addr = '0;
      d_in    = '0;
      busy    = (state != IDLE);
      unique case (state)
         WB_LO: begin
            wr      = 1'b1;
            wr_addr = cap_lo;
            d_in    = acc[W-1:0];
         end
         WB_HI: begin
            wr      = 1'b1;
            wr_addr = cap_hi;
            d_in    = acc[2*W-1:W];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_mult_wb.sv
// Bench for seq_mult_wb: register file model, scoreboard of expected writes/products,
// monitor comparing on the falling edge.
module tb_seq_mult_wb;

   localparam int W  = 16;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW-1:0]   rs_a, rs_b, rd_lo, rd_hi;
   logic [AW-1:0]   rd_addr_a, rd_addr_b, wr_addr;
   logic [W-1:0]    d_out_a, d_out_b, d_in;
   logic            wr, busy, done;
   logic [2*W-1:0]  product;

   logic [W-1:0]    mem     [8];
   logic [W-1:0]    ref_mem [8];
   logic            pre_we;
   logic [AW-1:0]   pre_addr;
   logic [W-1:0]    pre_data;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_err  = 0;

   typedef struct {logic [AW-1:0] addr; logic [W-1:0] data; int at;} wr_exp_t;
   typedef struct {logic [2*W-1:0] prod; int at;} done_exp_t;

   wr_exp_t   exp_wr[$];
   done_exp_t exp_done[$];

   seq_mult_wb #(.W(W), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rs_a(rs_a), .rs_b(rs_b), .rd_lo(rd_lo), .rd_hi(rd_hi),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .d_out_a(d_out_a), .d_out_b(d_out_b),
      .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: combinational read, synchronous write, bench preload port wins.
   assign d_out_a = mem[rd_addr_a];
   assign d_out_b = mem[rd_addr_b];
   always @(posedge clk) begin
      if (pre_we)  mem[pre_addr] <= pre_data;
      else if (wr) mem[wr_addr]  <= d_in;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr) begin
            if (exp_wr.size() == 0) check("wr_unexpected", wr, 0);
            else begin : pop_wr
               wr_exp_t e;
               e = exp_wr.pop_front();
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", d_in, e.data);
               check("wr_cycle", cyc, e.at);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) check("done_unexpected", done, 0);
            else begin : pop_done
               done_exp_t d;
               d = exp_done.pop_front();
               check("product", product, d.prod);
               check("done_cycle", cyc, d.at);
            end
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] v);
      pre_we = 1'b1; pre_addr = a; pre_data = v;
      @(posedge clk); #1;
      pre_we = 1'b0;
      ref_mem[a] = v;
      @(negedge clk);
   endtask

   // Called on a falling edge; returns on the falling edge of the done cycle.
   task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] lo, input logic [AW-1:0] hi, input bit extra);
      logic [2*W-1:0] p;
      int k;
      p = {{W{1'b0}}, ref_mem[a]} * {{W{1'b0}}, ref_mem[b]};
      rs_a = a; rs_b = b; rd_lo = lo; rd_hi = hi; start = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      start = 1'b0;
      rs_a = 3'($urandom); rs_b = 3'($urandom); rd_lo = 3'($urandom); rd_hi = 3'($urandom);
      exp_wr.push_back('{lo, p[W-1:0], k + 17});
      exp_wr.push_back('{hi, p[2*W-1:W], k + 18});
      exp_done.push_back('{p, k + 19});
      check("busy_cycle1", busy, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (extra && i == 9) begin
            start = 1'b1;
            rs_a = 3'($urandom); rd_lo = 3'($urandom); rd_hi = 3'($urandom);
         end
         if (extra && i == 10) start = 1'b0;
      end
      check("busy_done_cycle", busy, 0);
      ref_mem[lo] = p[W-1:0];
      ref_mem[hi] = p[2*W-1:W];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b1; start = 1'b0;
      rs_a = '0; rs_b = '0; rd_lo = '0; rd_hi = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_wr", wr, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_d_in", d_in, 0);
      check("rst_rd_addr_a", rd_addr_a, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

      preload(3, 16'hcdef);
      preload(7, 16'h3210);
      run_op(3, 7, 5, 0, 0);
      check("tp1_product", product, 32'h28458CF0);

      preload(1, 16'hFFFF);
      run_op(1, 1, 2, 3, 0);
      check("tp2_product", product, 32'hFFFE0001);
      check("tp2_r2", mem[2], 16'h0001);
      check("tp2_r3", mem[3], 16'hFFFE);

      preload(6, 16'h0000);
      preload(4, 16'hBA98);
      run_op(6, 4, 1, 7, 0);
      check("tp3_product", product, 0);

      preload(3, 16'h0003);
      preload(5, 16'h0005);
      run_op(3, 5, 4, 4, 0);
      check("tp4_product", product, 32'h0000000F);
      check("tp4_r4", mem[4], 16'h0000);

      // Ignored mid-operation start, then back-to-back ops started in the done cycle.
      run_op(2, 3, 6, 1, 1);
      for (int j = 0; j < 6; j++)
         run_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 0);

      // Abandon an operation with reset in cycle 12.
      @(negedge clk);
      preload(0, 16'hFFFF);
      preload(1, 16'hABCD);
      rs_a = 0; rs_b = 1; rd_lo = 2; rd_hi = 3; start = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      start = 1'b0;
      while (cyc < k + 11) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wr", wr, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_product", product, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_product", product, 0);

      for (int i = 0; i < 8; i++) check($sformatf("regfile_r%0d", i), mem[i], ref_mem[i]);
      check("writes_outstanding", exp_wr.size(), 0);
      check("dones_outstanding", exp_done.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
